// File: rtl/stream_downsizer.sv
// Stream downsizer: accepts DSIZE-bit words over a valid/ready handshake and
// emits them as DSIZE/OSIZE slices of OSIZE bits, least-significant slice
// first. A new word can be loaded on the same cycle the last slice leaves, so
// a continuous input stream produces one slice per cycle with no bubbles.
module stream_downsizer #(
    parameter int DSIZE = 32,
    parameter int OSIZE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_n,
    input  logic [DSIZE-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam int RATIO = DSIZE / OSIZE;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    // A word that does not split into whole slices is a configuration error.
    if (DSIZE % OSIZE != 0) begin : g_bad_ratio
        $error("stream_downsizer: DSIZE (%0d) must be a multiple of OSIZE (%0d)", DSIZE, OSIZE);
    end

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [DSIZE-1:0] hold;

    logic last_slice;
    logic out_hs;
    logic in_hs;

    // Handshake qualifiers and output decode; a low clear_n masks both sides.
    always_comb begin
        last_slice = (idx == LAST_IDX);
        out_valid  = (state == BUSY) && clear_n;
        out_last   = out_valid && last_slice;
        out_hs     = out_valid && out_ready;
        in_ready   = clear_n && ((state == EMPTY) || (out_hs && last_slice));
        in_hs      = in_valid && in_ready;
        out_data   = hold[int'(idx) * OSIZE +: OSIZE];
    end

    // Next-state and slice-index logic; clear overrides both handshakes.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can
        // leave a value unassigned and infer a latch.
        state_next = state;
        idx_next   = idx;
        if (!clear_n) begin
            state_next = EMPTY;
            idx_next   = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_hs) begin
                        state_next = BUSY;
                        idx_next   = '0;
                    end
                end
                BUSY: begin
                    if (out_hs) begin
                        if (last_slice) begin
                            // Reload on the last slice keeps the stream gapless.
                            state_next = in_hs ? BUSY : EMPTY;
                            idx_next   = '0;
                        end else begin
                            // Only reached below LAST_IDX, so idx stays in range
                            // even when RATIO is not a power of two.
                            idx_next = idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = EMPTY;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // State and index registers, forced empty asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers are written with <= so every flop samples the
        // pre-edge values, independent of statement order.
        if (!rst_n) begin
            state <= EMPTY;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Word hold register, loaded on every accepted input word.
    always_ff @(posedge clk) begin
        // NOTE: the data register has no reset; out_valid qualifies it, so a
        // reset here would only add routing to a wide datapath.
        if (in_hs) begin
            hold <= in_data;
        end
    end

endmodule

// File: tb/tb_stream_downsizer.sv
// Directed self-checking bench for stream_downsizer (DSIZE=32, OSIZE=8).
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_stream_downsizer;

    logic        clk;
    logic        rst_n;
    logic        clear_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int vectors;
    int miscompares;

    stream_downsizer #(
        .DSIZE(32),
        .OSIZE(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_n  (clear_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; land 1ns after the rising edge, then settle to mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Expect one valid slice on the current cycle.
    task automatic expect_slice(input string tag, input logic [7:0] data, input logic last);
        settle();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(data));
        check({tag, "_last"},  32'(out_last),  32'(last));
    endtask

    // Present one word for one cycle while the FSM is empty.
    task automatic send_word(input logic [31:0] word);
        in_data  = word;
        in_valid = 1'b1;
        settle();
        check("send_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    logic [7:0] bytes_a [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        clear_n     = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;

        // Reset held for three cycles: nothing valid, input side open.
        for (int i = 0; i < 3; i++) begin
            settle();
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_last",  32'(out_last),  32'd0);
            check("rst_in_ready",  32'(in_ready),  32'd1);
            step();
        end
        rst_n = 1'b1;
        settle();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_in_ready",  32'(in_ready),  32'd1);
        step();

        // Single word, LSB slice first, last flagged on slice 3.
        bytes_a = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_word(32'hDDCC_BBAA);
        for (int i = 0; i < 4; i++) begin
            expect_slice("single", bytes_a[i], i == 3);
            check("single_in_ready", 32'(in_ready), (i == 3) ? 32'd1 : 32'd0);
            step();
        end
        settle();
        check("single_drain_valid", 32'(out_valid), 32'd0);
        step();

        // Back-to-back words with in_valid held high: eight gapless slices.
        in_data  = 32'h0302_0100;
        in_valid = 1'b1;
        step();
        in_data = 32'h0706_0504;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) in_valid = 1'b0;
            expect_slice("b2b", 8'(i), (i == 3) || (i == 7));
            if (i == 3) check("b2b_reload_ready", 32'(in_ready), 32'd1);
            step();
        end
        settle();
        check("b2b_drain_valid", 32'(out_valid), 32'd0);
        step();

        // Backpressure on slice 0xBB for three cycles.
        send_word(32'hDDCC_BBAA);
        expect_slice("bp_aa", 8'hAA, 1'b0);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_slice("bp_stall", 8'hBB, 1'b0);
            step();
        end
        out_ready = 1'b1;
        expect_slice("bp_release", 8'hBB, 1'b0);
        step();
        expect_slice("bp_cc", 8'hCC, 1'b0);
        step();
        expect_slice("bp_dd", 8'hDD, 1'b1);
        step();

        // Synchronous clear after 0xAA and 0xBB have gone out.
        send_word(32'hDDCC_BBAA);
        expect_slice("clr_aa", 8'hAA, 1'b0);
        step();
        expect_slice("clr_bb", 8'hBB, 1'b0);
        step();
        clear_n = 1'b0;
        settle();
        check("clr_low_out_valid", 32'(out_valid), 32'd0);
        check("clr_low_in_ready",  32'(in_ready),  32'd0);
        step();
        clear_n = 1'b1;
        settle();
        check("clr_after_out_valid", 32'(out_valid), 32'd0);
        check("clr_after_in_ready",  32'(in_ready),  32'd1);
        step();
        send_word(32'h4433_2211);
        for (int i = 0; i < 4; i++) begin
            expect_slice("clr_next", 8'(8'h11 * (i + 1)), i == 3);
            step();
        end

        // Asynchronous reset pulsed while 0xCC is on the output.
        send_word(32'hDDCC_BBAA);
        step();
        step();
        #1;
        check("areset_pre_data", 32'(out_data), 32'hCC);
        rst_n = 1'b0;
        #1;
        check("areset_out_valid_drop", 32'(out_valid), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("areset_no_dd", 32'(out_valid), 32'd0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_downsizer.md
STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

Interface
REQ-001 The module SHALL have parameter DSIZE, default 32: input word width in bits.
REQ-002 The module SHALL have parameter OSIZE, default 8: output slice width in bits; DSIZE SHALL be an integer multiple of OSIZE.
REQ-003 The module SHALL have port clk  input  1: single clock, rising edge.
REQ-004 The module SHALL have port rst_n  input  1: asynchronous reset, active low.
REQ-005 The module SHALL have port clear_n  input  1: synchronous clear, active low.
REQ-006 The module SHALL have port in_data  input  DSIZE: input word.
REQ-007 The module SHALL have port in_valid  input  1: input word present.
REQ-008 The module SHALL have port in_ready  output  1: module can accept a word this cycle.
REQ-009 The module SHALL have port out_data  output  OSIZE: current output slice.
REQ-010 The module SHALL have port out_valid  output  1: out_data valid.
REQ-011 The module SHALL have port out_ready  input  1: downstream accepts the slice.
REQ-012 The module SHALL have port out_last  output  1: current slice is the final slice of its word.

Function
REQ-013 The module SHALL define RATIO = DSIZE/OSIZE and IDX_W = max(1, clog2(RATIO)) as local constants.
REQ-014 The module SHALL implement a two-state FSM: EMPTY (no word held) and BUSY (word held, slices pending).
REQ-015 An input handshake SHALL occur on a cycle where in_valid and in_ready are both 1; on that cycle the word SHALL be captured into a hold register, idx SHALL be set to 0 and the state SHALL become BUSY.
REQ-016 An output handshake SHALL occur on a cycle where out_valid and out_ready are both 1.
REQ-017 out_data SHALL equal hold[idx*OSIZE +: OSIZE]; slices SHALL be emitted LSB slice first.
REQ-018 out_valid SHALL be 1 only when the state is BUSY and clear_n is 1.
REQ-019 out_last SHALL be 1 only when out_valid is 1 and idx equals RATIO-1.
REQ-020 in_ready SHALL be 1 only when clear_n is 1 and either the state is EMPTY or an output handshake on the last slice occurs this cycle.
REQ-021 An output handshake on a non-last slice SHALL increment idx by 1.
REQ-022 An output handshake on the last slice without a simultaneous input handshake SHALL return the FSM to EMPTY.
REQ-023 An output handshake on the last slice with a simultaneous input handshake SHALL load the new word, reset idx to 0 and stay BUSY, with no bubble cycle.
REQ-024 First-slice latency SHALL be 1 cycle: a word accepted on cycle t SHALL present slice 0 with out_valid=1 on cycle t+1.
REQ-025 With out_ready held at 1 and words always available, throughput SHALL be one slice per cycle, i.e. RATIO cycles per word.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_last and idx SHALL remain stable.
REQ-027 idx SHALL never exceed RATIO-1, including when RATIO is not a power of two.
REQ-028 When RATIO=1, the module SHALL behave as a one-entry registered stage with out_last held at 1 whenever out_valid=1.
REQ-029 When clear_n=0 at a clock edge, the FSM SHALL go to EMPTY and idx to 0; clear SHALL take priority over both handshakes and any held word SHALL be discarded.

Reset
REQ-030 While rst_n=0, the FSM SHALL be EMPTY and idx SHALL be 0, asynchronously and regardless of clk.
REQ-031 During reset the outputs SHALL be out_valid=0 and out_last=0, and in_ready SHALL equal clear_n.
REQ-032 The hold register SHALL not be reset, and out_data SHALL be don't-care whenever out_valid=0.
REQ-033 Assertion of rst_n mid-word SHALL drop the word; no slice of that word SHALL appear after reset.

Structure
REQ-034 The design SHALL use no shared package; RATIO, IDX_W and the state encoding SHALL be module-local constants.
REQ-035 The design SHALL be a single module with no sub-module, implemented as one state register, one idx counter and one hold register.
REQ-036 Elaboration SHALL fail when DSIZE mod OSIZE is not 0.

Verification
REQ-037 Reset scenario: hold rst_n=0 for 3 cycles, then release -> out_valid=0 and in_ready=1 throughout.
REQ-038 Single word: 0xDDCCBBAA accepted at t with out_ready=1 -> out_data 0xAA,0xBB,0xCC,0xDD on t+1..t+4, out_last=1 only at t+4, in_ready=1 at t+4.
REQ-039 Back-to-back: 0x03020100 then 0x07060504 with in_valid held at 1 and out_ready=1 -> 8 consecutive slices 0x00..0x07 with no gap, out_last on 0x03 and 0x07.
REQ-040 Backpressure: out_ready=0 for 3 cycles while 0xBB is presented -> out_data stays 0xBB and out_valid stays 1; 0xCC follows one cycle after out_ready returns to 1.
REQ-041 Clear: clear_n=0 for 1 cycle after 0xAA and 0xBB are sent -> next cycle out_valid=0 and in_ready=1; the next word 0x44332211 emits from 0x11.
REQ-042 Mid-word async reset: rst_n pulsed low during slice 0xCC -> out_valid falls immediately and 0xDD is never emitted.
